// File: rtl/screen_sequencer_if.sv
// Bundle between the screen sequencer, the board keys, the renderer and the game core.
// The slave modport is the sequencer's own view of the bundle.
interface screen_sequencer_if;
  logic [3:0] KEY;
  logic       game_over;
  logic [1:0] screen;
  logic [1:0] menu_sel;
  logic       start_game;
  logic       abort_game;
  logic       item_pulse;
  logic [3:0] key_pulse;

  modport master (
    output KEY, game_over,
    input  screen, menu_sel, start_game, abort_game, item_pulse, key_pulse
  );

  modport slave (
    input  KEY, game_over,
    output screen, menu_sel, start_game, abort_game, item_pulse, key_pulse
  );
endinterface

// File: rtl/screen_sequencer.sv
// Screen-flow controller: key synchronise/debounce into press pulses, then the
// title/menu/game/result state machine with menu cursor and game strobes.
//
// state    | meaning
// S_TITLE  | title screen, any key enters the menu
// S_MENU   | menu, cursor moves with next/prev, select acts on the cursor
// S_GAME   | game running, back aborts, game_over shows the result
// S_RESULT | result screen, any key returns to the menu
module screen_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_ITEMS       = 3
) (
  input logic                CLOCK_50,
  input logic                resetn,
  screen_sequencer_if.slave  bus
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [1:0]     LAST    = 2'(NUM_ITEMS - 1);

  typedef enum logic [1:0] {
    S_TITLE  = 2'b00,
    S_MENU   = 2'b01,
    S_GAME   = 2'b10,
    S_RESULT = 2'b11
  } state_t;

  // Key conditioning; flops hold the active-high (pressed = 1) sense of KEY.
  logic [3:0]    sync1_q, sync2_q, stable_q, key_pulse_q;
  logic [CW-1:0] cnt_q [4];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      key_pulse_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= ~bus.KEY;
      sync2_q     <= sync1_q;
      key_pulse_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          stable_q[i]    <= sync2_q[i];
          cnt_q[i]       <= '0;
          key_pulse_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  state_t     state_q;
  logic [1:0] menu_sel_q;
  logic       start_q, abort_q, item_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_TITLE;
      menu_sel_q <= 2'd0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      item_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      item_q  <= 1'b0;
      case (state_q)
        S_TITLE, S_RESULT: begin
          if (|key_pulse_q) begin
            state_q    <= S_MENU;
            menu_sel_q <= 2'd0;
          end
        end
        S_MENU: begin
          // back > select > next > prev; lower-priority pulses are dropped
          if (key_pulse_q[3]) begin
            state_q <= S_TITLE;
          end else if (key_pulse_q[2]) begin
            if (menu_sel_q == 2'd0) begin
              state_q <= S_GAME;
              start_q <= 1'b1;
            end else begin
              item_q <= 1'b1;
            end
          end else if (key_pulse_q[0]) begin
            menu_sel_q <= (menu_sel_q == LAST) ? 2'd0 : menu_sel_q + 2'd1;
          end else if (key_pulse_q[1]) begin
            menu_sel_q <= (menu_sel_q == 2'd0) ? LAST : menu_sel_q - 2'd1;
          end
        end
        S_GAME: begin
          if (bus.game_over) begin
            state_q <= S_RESULT;
          end else if (key_pulse_q[3]) begin
            state_q    <= S_MENU;
            abort_q    <= 1'b1;
            menu_sel_q <= 2'd0;
          end
        end
        default: state_q <= S_TITLE;
      endcase
    end
  end

  assign bus.screen     = state_q;
  assign bus.menu_sel   = menu_sel_q;
  assign bus.start_game = start_q;
  assign bus.abort_game = abort_q;
  assign bus.item_pulse = item_q;
  assign bus.key_pulse  = key_pulse_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: key pulses are scoreboarded by expected
// vector and cycle, screen/cursor/strobes are checked after each step.
module tb_screen_sequencer;
  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] vec;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  screen_sequencer_if bus();

  screen_sequencer #(.DEBOUNCE_CYCLES(D), .NUM_ITEMS(3)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always @(negedge clk) begin : mon
    exp_t e;
    if (resetn && bus.key_pulse !== 4'h0) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (bus.key_pulse === 4'h0) else begin
          errors++;
          $error("FAIL spurious_pulse: observed %0h expected 0 at cycle %0d", bus.key_pulse, cyc);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        assert (bus.key_pulse === e.vec) else begin
          errors++;
          $error("FAIL pulse_vec: observed %0h expected %0h", bus.key_pulse, e.vec);
        end
        checks++;
        assert (cyc === e.at) else begin
          errors++;
          $error("FAIL pulse_cycle: observed %0d expected %0d", cyc, e.at);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [3:0] keys);
    exp_t e;
    e.vec = keys;
    e.at  = cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Leaves the caller at the negedge where the FSM has consumed the pulse.
  task automatic press(input logic [3:0] keys);
    bus.KEY = bus.KEY & ~keys;
    expect_pulse(keys);
    tick(LAT + 1);
  endtask

  task automatic release_keys();
    bus.KEY = 4'hF;
    tick(D + 6);
  endtask

  initial begin
    bus.KEY       = 4'hF;
    bus.game_over = 1'b0;
    tick(3);
    chk("rst_screen",    {2'b0, bus.screen},     4'h0);
    chk("rst_menu_sel",  {2'b0, bus.menu_sel},   4'h0);
    chk("rst_start",     {3'b0, bus.start_game}, 4'h0);
    chk("rst_abort",     {3'b0, bus.abort_game}, 4'h0);
    chk("rst_item",      {3'b0, bus.item_pulse}, 4'h0);
    chk("rst_key_pulse", bus.key_pulse,          4'h0);
    resetn = 1'b1;
    tick(3);

    press(4'b0010);
    chk("title_to_menu", {2'b0, bus.screen},   4'h1);
    chk("title_sel",     {2'b0, bus.menu_sel}, 4'h0);
    release_keys();

    press(4'b0001); chk("next1", {2'b0, bus.menu_sel}, 4'h1); release_keys();
    press(4'b0001); chk("next2", {2'b0, bus.menu_sel}, 4'h2); release_keys();
    press(4'b0001); chk("next_wrap", {2'b0, bus.menu_sel}, 4'h0); release_keys();
    press(4'b0010); chk("prev_wrap", {2'b0, bus.menu_sel}, 4'h2); release_keys();

    press(4'b0100);
    chk("item_pulse_hi", {3'b0, bus.item_pulse}, 4'h1);
    chk("item_screen",   {2'b0, bus.screen},     4'h1);
    chk("item_sel",      {2'b0, bus.menu_sel},   4'h2);
    tick(1);
    chk("item_pulse_lo", {3'b0, bus.item_pulse}, 4'h0);
    release_keys();

    press(4'b0001); chk("next_to0", {2'b0, bus.menu_sel}, 4'h0); release_keys();

    press(4'b0101);
    chk("start_screen", {2'b0, bus.screen},     4'h2);
    chk("start_hi",     {3'b0, bus.start_game}, 4'h1);
    chk("start_sel",    {2'b0, bus.menu_sel},   4'h0);
    tick(1);
    chk("start_lo",     {3'b0, bus.start_game}, 4'h0);
    release_keys();

    for (int i = 0; i < 4; i++) begin
      bus.KEY[0] = 1'b0; tick(3);
      bus.KEY[0] = 1'b1; tick(1);
    end
    bus.KEY[0] = 1'b0;
    expect_pulse(4'b0001);
    tick(LAT + 20);
    chk("bounce_game_ignores_next", {2'b0, bus.screen}, 4'h2);
    release_keys();

    bus.KEY[3] = 1'b0;
    expect_pulse(4'b1000);
    tick(LAT);
    bus.game_over = 1'b1;
    tick(1);
    bus.game_over = 1'b0;
    chk("over_wins_screen", {2'b0, bus.screen},     4'h3);
    chk("over_wins_abort",  {3'b0, bus.abort_game}, 4'h0);
    tick(1);
    chk("over_wins_abort2", {3'b0, bus.abort_game}, 4'h0);
    release_keys();

    press(4'b0001);
    chk("result_to_menu", {2'b0, bus.screen},   4'h1);
    chk("result_sel",     {2'b0, bus.menu_sel}, 4'h0);
    release_keys();

    bus.game_over = 1'b1; tick(1); bus.game_over = 1'b0; tick(1);
    chk("over_ignored_menu", {2'b0, bus.screen}, 4'h1);

    press(4'b0100); chk("game_again", {2'b0, bus.screen}, 4'h2); release_keys();
    press(4'b1000);
    chk("abort_screen", {2'b0, bus.screen},     4'h1);
    chk("abort_hi",     {3'b0, bus.abort_game}, 4'h1);
    tick(1);
    chk("abort_lo",     {3'b0, bus.abort_game}, 4'h0);
    release_keys();

    press(4'b1000); chk("back_to_title", {2'b0, bus.screen}, 4'h0); release_keys();
    press(4'b0100); chk("title_any",     {2'b0, bus.screen}, 4'h1); release_keys();
    press(4'b0100); chk("game_pre_rst",  {2'b0, bus.screen}, 4'h2); release_keys();

    bus.KEY[3] = 1'b0;
    tick(3);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_screen", {2'b0, bus.screen},     4'h0);
    chk("async_rst_sel",    {2'b0, bus.menu_sel},   4'h0);
    chk("async_rst_start",  {3'b0, bus.start_game}, 4'h0);
    chk("async_rst_abort",  {3'b0, bus.abort_game}, 4'h0);
    bus.KEY = 4'hF;
    tick(3);
    resetn = 1'b1;
    tick(20);
    chk("no_pulse_after_rst", {2'b0, bus.screen}, 4'h0);

    resetn = 1'b0;
    bus.KEY[0] = 1'b0;
    tick(5);
    resetn = 1'b1;
    expect_pulse(4'b0001);
    tick(LAT);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_key_pulse", bus.key_pulse, 4'h0);
    chk("async_rst_screen2",   {2'b0, bus.screen}, 4'h0);
    bus.KEY = 4'hF;
    tick(2);
    resetn = 1'b1;
    tick(20);
    chk("killed_pulse_no_move", {2'b0, bus.screen}, 4'h0);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL missing_pulses: observed %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level UI controller for the game's screen flow. Takes the four raw DE-board push buttons, synchronises and debounces them into one-cycle press pulses, and runs the title / menu / game / result screen state machine. It also owns the menu cursor and issues start/abort strobes to the game datapath. It sits between the board KEY inputs and both the renderer, which reads `screen` and `menu_sel`, and the game core, which consumes `start_game` and `abort_game` and returns `game_over`.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised key must hold a new level before it is accepted (20 ms at 50 MHz); legal range ≥1.
- NUM_ITEMS, 3, number of menu entries; legal range 2–4. Item 0 is "Start game".

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- CLOCK_50, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset.
- KEY, in, 4, raw push buttons, active-low, asynchronous to CLOCK_50. Roles: [0] next, [1] prev, [2] select, [3] back.
- game_over, in, 1, one-cycle pulse from the game core; only honoured in GAME.
- screen, out, 2, current screen: 00 TITLE, 01 MENU, 10 GAME, 11 RESULT.
- menu_sel, out, 2, menu cursor, 0..NUM_ITEMS-1.
- start_game, out, 1, one-cycle strobe telling the game core to start.
- abort_game, out, 1, one-cycle strobe telling the game core to abandon the current game.
- item_pulse, out, 1, one-cycle strobe when a non-zero menu item is selected; the selected index is on menu_sel in the same cycle.
- key_pulse, out, 4, debounced one-cycle press strobes (active-high), exported for debug LEDs.

## Operation
- Input conditioning, per key:
  - Two-flop synchroniser, then inversion to active-high.
  - Debounce counter, cleared whenever the synchronised value equals the stable value.
  - While the two differ, the counter increments. When it reaches DEBOUNCE_CYCLES, the stable value takes the synchronised value and the counter clears.
  - key_pulse[i] is high for exactly one cycle on a stable 0→1 transition. Releases produce no pulse.
- FSM (registered, state = screen):
  - TITLE: any key_pulse → MENU, menu_sel←0.
  - MENU, priority back > select > next > prev; lower-priority pulses in the same cycle are dropped:
    - back → TITLE.
    - select with menu_sel=0 → GAME, start_game=1.
    - select with menu_sel≠0 → stay in MENU, item_pulse=1.
    - next → menu_sel+1, wrapping NUM_ITEMS-1→0.
    - prev → menu_sel-1, wrapping 0→NUM_ITEMS-1.
  - GAME: game_over → RESULT. Otherwise back → MENU, abort_game=1, menu_sel←0. All other keys are ignored. If game_over and back arrive in the same cycle, game_over wins: no abort, go to RESULT.
  - RESULT: any key_pulse → MENU, menu_sel←0.
- game_over outside GAME is ignored.
- Strobes (start_game, abort_game, item_pulse) are registered and never high for more than one cycle per press.
- Reset values (asynchronous, on resetn low):
  - Outputs: screen=00, menu_sel=0, start_game=0, abort_game=0, item_pulse=0, key_pulse=0.
  - Internal: synchroniser flops=0 (released), stable=0, counters=0.
  - Reset mid-press: the key must go through a full DEBOUNCE_CYCLES qualification after release of resetn, which then yields exactly one pulse.

## Timing
- KEY[i] falls and stays low: the first edge sampling it is edge 0. key_pulse[i] is high during the cycle after edge DEBOUNCE_CYCLES+2. Total latency is DEBOUNCE_CYCLES+2 cycles.
- The FSM consumes key_pulse in the cycle it is high. screen, menu_sel and all strobes update on the following edge, so they lag key_pulse by 1 cycle.
- start_game and abort_game are high in the same cycle screen first shows the new value.
- game_over is sampled in the cycle it is high. screen=11 appears on the next edge.
- A bounce shorter than DEBOUNCE_CYCLES resets the counter and produces no pulse. A key held indefinitely produces one pulse only.
- Keys are debounced independently, so simultaneous presses produce same-cycle pulses that are resolved by the FSM priority.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_ITEMS=3.
- Reset, then press KEY[1] cleanly: key_pulse[1] high exactly 6 cycles after the first low sample. screen goes 00→01 one cycle later and menu_sel=0.
- In MENU, next ×3 then prev ×1: menu_sel goes 1,2,0 then 2. A prev from menu_sel=0 gives 2.
- In MENU with menu_sel=0, press select: screen=10 and start_game high exactly one cycle. With menu_sel=2, select gives item_pulse for one cycle and screen stays 01.
- KEY[0] toggles low 3 cycles / high 1 cycle repeatedly, then holds low: no pulse during the bounce. Exactly one key_pulse[0] appears 6 cycles after the final low, and none follows while held.
- In GAME, assert game_over and a back pulse in the same cycle: screen=11 and abort_game stays 0. Then any key: screen=01, menu_sel=0. Back alone in GAME: screen=01 with a 1-cycle abort_game.
- Drop resetn mid-debounce and mid-GAME: all outputs go to reset values immediately (asynchronously), and there is no spurious pulse after resetn rises with keys released.
